// File: rtl/kmeans_pkg.sv
// Shared definitions for the 2-cluster, 2-dimension k-means controller.
//   state_e    : controller FSM state encoding
//   PIPE_LATENCY : default distance/decision pipeline depth
//   sum_width / cnt_width : accumulator and point-counter widths
package kmeans_pkg;

    localparam int unsigned PIPE_LATENCY = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StDrain,
        StDiv,
        StUpdate,
        StDone
    } state_e;

    // A sum of up to 2**aw coordinates of dw bits never overflows dw+aw bits.
    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned aw);
        return dw + aw;
    endfunction

    // Counts reach 2**aw, which needs one extra bit.
    function automatic int unsigned cnt_width(input int unsigned aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/kmeans_seq_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : latch operands and begin (divisor_i must be non-zero)
//   dividend_i     : Width-bit dividend
//   divisor_i      : Width-bit divisor
//   done_o         : one-cycle pulse, quotient_o valid from this cycle until next start
//   quotient_o     : low OutWidth bits of the truncated quotient
module kmeans_seq_div #(
    parameter int unsigned Width    = 24,
    parameter int unsigned OutWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [Width-1:0]    dividend_i,
    input  logic [Width-1:0]    divisor_i,
    output logic                done_o,
    output logic [OutWidth-1:0] quotient_o
);

    localparam int unsigned CntW = $clog2(Width + 1);

    logic [Width:0]    rem_q;
    logic [Width-1:0]  quo_q;
    logic [Width-1:0]  div_q;
    logic [CntW-1:0]   cnt_q;
    logic              run_q;
    logic              done_q;

    logic [Width:0]    shifted;
    logic [Width:0]    trial;
    logic              fits;

    // Remainder stays below the divisor, so its top bit is free for the shift-in.
    always_comb begin
        shifted = {rem_q[Width-1:0], quo_q[Width-1]};
        trial   = shifted - {1'b0, div_q};
        fits    = (shifted >= {1'b0, div_q});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q <= '0;
                quo_q <= dividend_i;
                div_q <= divisor_i;
                cnt_q <= CntW'(Width);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= fits ? trial : shifted;
                quo_q <= {quo_q[Width-2:0], fits};
                cnt_q <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q[OutWidth-1:0];

endmodule

// File: rtl/kmeans_k2n2_ctrl.sv
// Iteration sequencer for the 2-cluster, 2-dimension k-means pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin clustering (sampled only when idle)
//   mem_rd_addr         : point address to the d0/d1 memories
//   kp_k_out            : pipeline cluster decision (1 = cluster 1)
//   kp_d0_out/kp_d1_out : point coordinates aligned with kp_k_out
//   k0_0..k1_1          : current centroids, fed back to the pipeline
//   busy                : high whenever not idle
//   done                : one-cycle pulse at the end of clustering
//   iter_count          : passes completed since the last start
module kmeans_k2n2_ctrl
    import kmeans_pkg::*;
#(
    parameter int unsigned          data_width           = 16,
    parameter int unsigned          n_input_data_b_depth = 8,
    parameter int unsigned          n_input_data         = 256,
    parameter int unsigned          pipe_latency         = PIPE_LATENCY,
    parameter int unsigned          max_iter             = 16,
    parameter logic [data_width-1:0] p_k0_0              = '0,
    parameter logic [data_width-1:0] p_k0_1              = '0,
    parameter logic [data_width-1:0] p_k1_0              = data_width'(1),
    parameter logic [data_width-1:0] p_k1_1              = data_width'(1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic [n_input_data_b_depth-1:0] mem_rd_addr,
    input  logic                            kp_k_out,
    input  logic [data_width-1:0]           kp_d0_out,
    input  logic [data_width-1:0]           kp_d1_out,
    output logic [data_width-1:0]           k0_0,
    output logic [data_width-1:0]           k0_1,
    output logic [data_width-1:0]           k1_0,
    output logic [data_width-1:0]           k1_1,
    output logic                            busy,
    output logic                            done,
    output logic [7:0]                      iter_count
);

    localparam int unsigned AW = n_input_data_b_depth;
    localparam int unsigned SW = sum_width(data_width, n_input_data_b_depth);
    localparam int unsigned CW = cnt_width(n_input_data_b_depth);

    localparam logic [AW-1:0] LastAddr   = AW'(n_input_data - 1);
    localparam logic [7:0]    DrainLast  = 8'(pipe_latency - 1);
    localparam logic [7:0]    IterLimit  = 8'(max_iter);
    // Index order 0..3 = k0_0, k0_1, k1_0, k1_1, matching the division order.
    localparam logic [3:0][data_width-1:0] PK = {p_k1_1, p_k1_0, p_k0_1, p_k0_0};

    state_e                      state_q;
    logic [AW-1:0]               addr_q;
    logic [pipe_latency-1:0]     valid_q;
    logic [pipe_latency-1:0]     valid_d;
    logic [7:0]                  drain_q;
    logic [SW-1:0]               sum0_x_q, sum0_y_q, sum1_x_q, sum1_y_q;
    logic [CW-1:0]               cnt0_q, cnt1_q;
    logic [3:0][data_width-1:0]  k_q;
    logic [3:0][data_width-1:0]  nk_q;
    logic [7:0]                  iter_q;
    logic [7:0]                  iter_inc;
    logic                        busy_q;
    logic                        done_q;
    logic [1:0]                  div_idx_q;
    logic                        div_wait_q;
    logic                        div_start_q;

    logic [SW-1:0]               div_dividend;
    logic [CW-1:0]               div_cnt;
    logic                        div_done;
    logic [data_width-1:0]       div_quotient;
    logic                        acc_en;
    logic                        changed;

    // Valid line tracks which pipeline output cycles carry a real point.
    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = (state_q == StFeed);
    end

    always_comb begin
        div_dividend = '0;
        div_cnt      = '0;
        case (div_idx_q)
            2'd0: begin div_dividend = sum0_x_q; div_cnt = cnt0_q; end
            2'd1: begin div_dividend = sum0_y_q; div_cnt = cnt0_q; end
            2'd2: begin div_dividend = sum1_x_q; div_cnt = cnt1_q; end
            default: begin div_dividend = sum1_y_q; div_cnt = cnt1_q; end
        endcase
    end

    assign acc_en   = valid_q[pipe_latency-1] && (state_q == StFeed || state_q == StDrain);
    assign changed  = (nk_q != k_q);
    assign iter_inc = iter_q + 8'd1;

    kmeans_seq_div #(
        .Width    (SW),
        .OutWidth (data_width)
    ) u_div (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (div_start_q),
        .dividend_i (div_dividend),
        .divisor_i  (SW'(div_cnt)),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            valid_q     <= '0;
            drain_q     <= '0;
            sum0_x_q    <= '0;
            sum0_y_q    <= '0;
            sum1_x_q    <= '0;
            sum1_y_q    <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            k_q         <= PK;
            nk_q        <= PK;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_idx_q   <= '0;
            div_wait_q  <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            div_start_q <= 1'b0;
            valid_q     <= valid_d;

            if (acc_en) begin
                if (!kp_k_out) begin
                    sum0_x_q <= sum0_x_q + SW'(kp_d0_out);
                    sum0_y_q <= sum0_y_q + SW'(kp_d1_out);
                    cnt0_q   <= cnt0_q + CW'(1);
                end else begin
                    sum1_x_q <= sum1_x_q + SW'(kp_d0_out);
                    sum1_y_q <= sum1_y_q + SW'(kp_d1_out);
                    cnt1_q   <= cnt1_q + CW'(1);
                end
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        k_q      <= PK;
                        iter_q   <= '0;
                        sum0_x_q <= '0;
                        sum0_y_q <= '0;
                        sum1_x_q <= '0;
                        sum1_y_q <= '0;
                        cnt0_q   <= '0;
                        cnt1_q   <= '0;
                        addr_q   <= '0;
                        valid_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StFeed;
                    end
                end
                StFeed: begin
                    if (addr_q == LastAddr) begin
                        addr_q  <= '0;
                        drain_q <= '0;
                        state_q <= StDrain;
                    end else begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                StDrain: begin
                    if (drain_q == DrainLast) begin
                        div_idx_q  <= '0;
                        div_wait_q <= 1'b0;
                        state_q    <= StDiv;
                    end else begin
                        drain_q <= drain_q + 8'd1;
                    end
                end
                StDiv: begin
                    if (!div_wait_q) begin
                        if (div_cnt == '0) begin
                            // Empty cluster keeps its old coordinate.
                            nk_q[div_idx_q] <= k_q[div_idx_q];
                            if (div_idx_q == 2'd3) state_q <= StUpdate;
                            else                   div_idx_q <= div_idx_q + 2'd1;
                        end else begin
                            div_start_q <= 1'b1;
                            div_wait_q  <= 1'b1;
                        end
                    end else if (div_done) begin
                        nk_q[div_idx_q] <= div_quotient;
                        div_wait_q      <= 1'b0;
                        if (div_idx_q == 2'd3) state_q <= StUpdate;
                        else                   div_idx_q <= div_idx_q + 2'd1;
                    end
                end
                StUpdate: begin
                    iter_q <= iter_inc;
                    k_q    <= nk_q;
                    if (!changed || iter_inc == IterLimit) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        sum0_x_q <= '0;
                        sum0_y_q <= '0;
                        sum1_x_q <= '0;
                        sum1_y_q <= '0;
                        cnt0_q   <= '0;
                        cnt1_q   <= '0;
                        addr_q   <= '0;
                        state_q  <= StFeed;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_rd_addr = addr_q;
    assign k0_0        = k_q[0];
    assign k0_1        = k_q[1];
    assign k1_0        = k_q[2];
    assign k1_1        = k_q[3];
    assign busy        = busy_q;
    assign done        = done_q;
    assign iter_count  = iter_q;

endmodule

// File: tb/tb_kmeans_k2n2_ctrl.sv
// Directed bench: four controller instances, each with an ideal nearest-centroid pipeline model.
//   0: n=4, default init      1: n=4, max_iter=1
//   2: n=4, k1 init (1000,1000) 3: n=256, all points 0xFFFF
module tb_kmeans_k2n2_ctrl;
    import kmeans_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = 4'b0;
    logic [7:0]  addr [4];
    logic        kk   [4];
    logic [15:0] kd0  [4];
    logic [15:0] kd1  [4];
    logic [15:0] c00 [4], c01 [4], c10 [4], c11 [4];
    logic [3:0]  busy, done;
    logic [7:0]  iter [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kmeans_k2n2_ctrl #(.n_input_data(4)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .mem_rd_addr(addr[0]),
        .kp_k_out(kk[0]), .kp_d0_out(kd0[0]), .kp_d1_out(kd1[0]),
        .k0_0(c00[0]), .k0_1(c01[0]), .k1_0(c10[0]), .k1_1(c11[0]),
        .busy(busy[0]), .done(done[0]), .iter_count(iter[0]));

    kmeans_k2n2_ctrl #(.n_input_data(4), .max_iter(1)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .mem_rd_addr(addr[1]),
        .kp_k_out(kk[1]), .kp_d0_out(kd0[1]), .kp_d1_out(kd1[1]),
        .k0_0(c00[1]), .k0_1(c01[1]), .k1_0(c10[1]), .k1_1(c11[1]),
        .busy(busy[1]), .done(done[1]), .iter_count(iter[1]));

    kmeans_k2n2_ctrl #(.n_input_data(4), .p_k1_0(16'd1000), .p_k1_1(16'd1000)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .mem_rd_addr(addr[2]),
        .kp_k_out(kk[2]), .kp_d0_out(kd0[2]), .kp_d1_out(kd1[2]),
        .k0_0(c00[2]), .k0_1(c01[2]), .k1_0(c10[2]), .k1_1(c11[2]),
        .busy(busy[2]), .done(done[2]), .iter_count(iter[2]));

    kmeans_k2n2_ctrl #(.n_input_data(256)) u_d (
        .clk(clk), .rst(rst), .start(start[3]), .mem_rd_addr(addr[3]),
        .kp_k_out(kk[3]), .kp_d0_out(kd0[3]), .kp_d1_out(kd1[3]),
        .k0_0(c00[3]), .k0_1(c01[3]), .k1_0(c10[3]), .k1_1(c11[3]),
        .busy(busy[3]), .done(done[3]), .iter_count(iter[3]));

    // ---------------- datapath model ----------------
    function automatic logic [15:0] px_of(input int i, input logic [7:0] a);
        if (i == 3) return 16'hFFFF;
        return (a[1:0] >= 2'd2) ? 16'd10 : 16'd0;
    endfunction

    function automatic logic [15:0] py_of(input int i, input logic [7:0] a);
        if (i == 3) return 16'hFFFF;
        case (a[1:0])
            2'd0:    return 16'd0;
            2'd1:    return 16'd2;
            2'd2:    return 16'd10;
            default: return 16'd12;
        endcase
    endfunction

    function automatic logic near1(input logic [15:0] x, input logic [15:0] y,
                                   input logic [15:0] a0, input logic [15:0] a1,
                                   input logic [15:0] b0, input logic [15:0] b1);
        longint dx0, dy0, dx1, dy1;
        dx0 = longint'(x) - longint'(a0);
        dy0 = longint'(y) - longint'(a1);
        dx1 = longint'(x) - longint'(b0);
        dy1 = longint'(y) - longint'(b1);
        return (dx1 * dx1 + dy1 * dy1) <= (dx0 * dx0 + dy0 * dy0);
    endfunction

    logic        pk [4][4];
    logic [15:0] pxs [4][4];
    logic [15:0] pys [4][4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int s = 3; s > 0; s--) begin
                pk[i][s]  <= pk[i][s-1];
                pxs[i][s] <= pxs[i][s-1];
                pys[i][s] <= pys[i][s-1];
            end
            pk[i][0]  <= near1(px_of(i, addr[i]), py_of(i, addr[i]),
                               c00[i], c01[i], c10[i], c11[i]);
            pxs[i][0] <= px_of(i, addr[i]);
            pys[i][0] <= py_of(i, addr[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            kk[i]  = pk[i][3];
            kd0[i] = pxs[i][3];
            kd1[i] = pys[i][3];
        end
    end

    // ---------------- observers ----------------
    int         c_starts = 0;
    int         c_starts_k1 = 0;
    int         a_feed_cnt = 0;
    int         a_addr_err = 0;
    logic [1:0] a_exp_addr = 2'd0;

    always @(posedge clk) begin
        if (u_c.div_start_q) begin
            c_starts <= c_starts + 1;
            if (u_c.div_idx_q[1]) c_starts_k1 <= c_starts_k1 + 1;
        end
        if (rst) begin
            a_exp_addr <= 2'd0;
        end else if (u_a.state_q == StFeed) begin
            a_feed_cnt <= a_feed_cnt + 1;
            if (addr[0] !== {6'd0, a_exp_addr}) a_addr_err <= a_addr_err + 1;
            a_exp_addr <= a_exp_addr + 2'd1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (done[i] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done[i]), 32'd1);
    endtask

    task automatic wait_a_state(input state_e st);
        int n = 0;
        while (u_a.state_q != st && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("a_state_reached", 32'(u_a.state_q), 32'(st));
    endtask

    task automatic check_k(input string tag, input int i, input logic [15:0] e00,
                           input logic [15:0] e01, input logic [15:0] e10,
                           input logic [15:0] e11);
        check({tag, "_k0_0"}, 32'(c00[i]), 32'(e00));
        check({tag, "_k0_1"}, 32'(c01[i]), 32'(e01));
        check({tag, "_k1_0"}, 32'(c10[i]), 32'(e10));
        check({tag, "_k1_1"}, 32'(c11[i]), 32'(e11));
    endtask

    // Expected centroids after each pass of the n=4 run.
    logic [15:0] exp_pass [3][4];
    int          feed0;

    initial begin
        exp_pass[0] = '{16'd0, 16'd0, 16'd6, 16'd8};
        exp_pass[1] = '{16'd0, 16'd1, 16'd10, 16'd11};
        exp_pass[2] = '{16'd0, 16'd1, 16'd10, 16'd11};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_addr", 32'(addr[0]), 32'd0);
        check("rst_iter", 32'(iter[0]), 32'd0);
        check_k("rst", 0, 16'd0, 16'd0, 16'd1, 16'd1);

        // Convergence run with start pulses during DRAIN and DIV
        feed0 = a_feed_cnt;
        pulse_start(0);
        check("run_busy", 32'(busy[0]), 32'd1);
        for (int p = 0; p < 3; p++) begin
            if (p == 0) begin
                wait_a_state(StDrain);
                pulse_start(0);
                wait_a_state(StDiv);
                pulse_start(0);
            end
            wait_a_state(StUpdate);
            check($sformatf("pass%0d_cnt_sum", p + 1),
                  32'(u_a.cnt0_q) + 32'(u_a.cnt1_q), 32'd4);
            check_k($sformatf("pass%0d_hold", p + 1), 0,
                    (p == 0) ? 16'd0 : exp_pass[p-1][0], (p == 0) ? 16'd0 : exp_pass[p-1][1],
                    (p == 0) ? 16'd1 : exp_pass[p-1][2], (p == 0) ? 16'd1 : exp_pass[p-1][3]);
            @(negedge clk);
            check_k($sformatf("pass%0d", p + 1), 0,
                    exp_pass[p][0], exp_pass[p][1], exp_pass[p][2], exp_pass[p][3]);
        end
        check("conv_done", 32'(done[0]), 32'd1);
        check("conv_busy_in_done", 32'(busy[0]), 32'd1);
        check("conv_iter", 32'(iter[0]), 32'd3);
        @(negedge clk);
        check("conv_done_single", 32'(done[0]), 32'd0);
        check("conv_idle_busy", 32'(busy[0]), 32'd0);
        check("conv_feed_cycles", 32'(a_feed_cnt - feed0), 32'd12);
        check("conv_addr_seq_err", 32'(a_addr_err), 32'd0);
        repeat (3) @(negedge clk);
        check("conv_hold_iter", 32'(iter[0]), 32'd3);
        check_k("conv_hold", 0, 16'd0, 16'd1, 16'd10, 16'd11);

        // max_iter = 1
        pulse_start(1);
        wait_done(1);
        check("mi1_iter", 32'(iter[1]), 32'd1);
        check_k("mi1", 1, 16'd0, 16'd0, 16'd6, 16'd8);

        // Empty cluster 1
        pulse_start(2);
        wait_done(2);
        check("empty_iter", 32'(iter[2]), 32'd2);
        check_k("empty", 2, 16'd5, 16'd6, 16'd1000, 16'd1000);
        check("empty_div_starts", 32'(c_starts), 32'd4);
        check("empty_k1_div_starts", 32'(c_starts_k1), 32'd0);

        // 256 points at full scale
        pulse_start(3);
        wait_done(3);
        check("full_iter", 32'(iter[3]), 32'd2);
        check_k("full", 3, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF);
        check("full_sum1_x", 32'(u_d.sum1_x_q), 32'h00FF_FF00);
        check("full_cnt1", 32'(u_d.cnt1_q), 32'd256);

        // Reset in the middle of the second pass, then restart
        pulse_start(0);
        begin
            int n = 0;
            while (!(u_a.state_q == StFeed && iter[0] == 8'd1 && addr[0] == 8'd2) && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("midrst_reached", 32'(addr[0]), 32'd2);
        end
        check("midrst_k1_moved", 32'(c10[0]), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_addr", 32'(addr[0]), 32'd0);
        check("midrst_iter", 32'(iter[0]), 32'd0);
        check("midrst_valid", 32'(u_a.valid_q), 32'd0);
        check("midrst_idle", 32'(u_a.state_q), 32'(StIdle));
        check_k("midrst", 0, 16'd0, 16'd0, 16'd1, 16'd1);
        pulse_start(0);
        wait_done(0);
        check("restart_iter", 32'(iter[0]), 32'd3);
        check_k("restart", 0, 16'd0, 16'd1, 16'd10, 16'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
